// File: rtl/sipo_frame_rx.sv
// Serial-in frame receiver: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Completed words are held in a single-entry output register with a valid/ready handshake.
module sipo_frame_rx #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned PARITY_EN = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              si,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_perr,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);

   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] sreg;
   logic              par_err;
   logic              stop_ok;
   logic              stop_bad;
   logic              load;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      stop_ok   = 1'b0;
      stop_bad  = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (!si) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
               state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: begin
            state_nxt = STOP;
         end
         STOP: begin
            state_nxt = IDLE;
            stop_ok   = si;
            stop_bad  = ~si;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // A finished word may load only if the holding register is empty or being drained this edge.
   assign load = stop_ok && (!out_valid || out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= '0;
         sreg      <= '0;
         par_err   <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_perr  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= stop_ok && out_valid && !out_ready;

         case (state)
            IDLE: begin
               bit_cnt <= '0;
               par_err <= 1'b0;
            end
            DATA: begin
               sreg[bit_cnt] <= si;
               bit_cnt       <= bit_cnt + CNT_W'(1);
            end
            PARITY: begin
               par_err <= (^sreg) ^ si;
            end
            default: begin
            end
         endcase

         if (load) begin
            out_data  <= sreg;
            out_perr  <= (PARITY_EN != 0) && par_err;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: frame-level reference model checked every cycle, a table of
// single-frame vectors, hand sequences for overrun/reset/back-to-back, then random traffic.
module tb_sipo_frame_rx;

   localparam int K_IDLE  = 0;
   localparam int K_START = 1;
   localparam int K_MID   = 2;
   localparam int K_STOP  = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       si;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_perr;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   // frame-level expectation of the holding register
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_perr;
   logic [7:0] f_data;
   logic       f_perr;

   typedef struct {
      logic [7:0] d;
      logic       par;
      logic       stop;
      logic       ev;
      logic [7:0] ed;
      logic       ep;
      logic       efe;
   } vec_t;

   vec_t tbl[9];

   sipo_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .si        (si),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_perr  (out_perr),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic pick_rdy(input int m);
      if (m == 2) return 1'($urandom_range(0, 1));
      return (m != 0);
   endfunction

   // One clock: drive si/out_ready, advance the model by the frame rules, compare all outputs.
   task automatic step(input logic s, input logic r, input int kind);
      logic exp_fe;
      logic exp_ov;
      logic exp_busy;
      logic is_stop;
      si        = s;
      out_ready = r;
      @(posedge clk);
      #1;
      is_stop  = (kind == K_STOP);
      exp_fe   = is_stop && !s;
      exp_ov   = is_stop && s && m_valid && !r;
      exp_busy = (kind == K_START) || (kind == K_MID);
      if (is_stop && s && (!m_valid || r)) begin
         m_valid = 1'b1;
         m_data  = f_data;
         m_perr  = f_perr;
      end else if (m_valid && r) begin
         m_valid = 1'b0;
      end
      check("valid", out_valid, m_valid);
      check("data", out_data, m_data);
      if (m_valid) check("perr", out_perr, m_perr);
      check("frame_err", frame_err, exp_fe);
      check("overrun", overrun, exp_ov);
      check("busy", busy, exp_busy);
   endtask

   task automatic rst_step();
      rst       = 1'b1;
      si        = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      m_valid = 1'b0;
      m_data  = '0;
      m_perr  = 1'b0;
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, 8'h00);
      check("rst_perr", out_perr, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_busy", busy, 1'b0);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int rmode);
      f_data = d;
      f_perr = (^d) ^ par;
      step(1'b0, pick_rdy(rmode), K_START);
      for (int i = 0; i < 8; i++) step(d[i], pick_rdy(rmode), K_MID);
      step(par, pick_rdy(rmode), K_MID);
      step(stop, pick_rdy(rmode), K_STOP);
   endtask

   task automatic idle(input int n, input int rmode);
      for (int i = 0; i < n; i++) step(1'b1, pick_rdy(rmode), K_IDLE);
   endtask

   initial begin
      logic [7:0] d;
      logic       par;
      logic       stop;
      int         nb;

      tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
      tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
      tbl[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
      tbl[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
      tbl[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
      tbl[5] = '{8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
      tbl[6] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0};
      tbl[7] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};
      tbl[8] = '{8'h7E, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};

      rst       = 1'b1;
      si        = 1'b1;
      out_ready = 1'b0;
      m_valid   = 1'b0;
      m_data    = '0;
      m_perr    = 1'b0;
      f_data    = '0;
      f_perr    = 1'b0;
      rst_step();
      rst_step();

      // single frames from an empty holding register, compared one cycle after the stop sample
      for (int i = 0; i < 9; i++) begin
         idle(2, 1);
         send_frame(tbl[i].d, tbl[i].par, tbl[i].stop, 1);
         check("tbl_valid", out_valid, tbl[i].ev);
         check("tbl_data", out_data, tbl[i].ed);
         if (tbl[i].ev) check("tbl_perr", out_perr, tbl[i].ep);
         check("tbl_frame_err", frame_err, tbl[i].efe);
         check("tbl_overrun", overrun, 1'b0);
      end

      // overrun: second back-to-back frame dropped while consumer stalls
      idle(2, 1);
      send_frame(8'hA5, 1'b0, 1'b1, 0);
      check("ovr_first_valid", out_valid, 1'b1);
      check("ovr_first_data", out_data, 8'hA5);
      send_frame(8'h5A, 1'b0, 1'b1, 0);
      check("ovr_pulse", overrun, 1'b1);
      check("ovr_held_data", out_data, 8'hA5);
      check("ovr_held_valid", out_valid, 1'b1);
      step(1'b1, 1'b0, K_IDLE);
      check("ovr_pulse_end", overrun, 1'b0);
      check("ovr_still_held", out_data, 8'hA5);
      step(1'b1, 1'b1, K_IDLE);
      check("ovr_drain", out_valid, 1'b0);

      // reset after four data bits of 0xFF abandons the frame
      idle(2, 1);
      step(1'b0, 1'b1, K_START);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, K_MID);
      rst_step();
      check("abort_busy", busy, 1'b0);
      idle(1, 1);
      send_frame(8'h81, 1'b0, 1'b1, 1);
      check("after_rst_valid", out_valid, 1'b1);
      check("after_rst_data", out_data, 8'h81);
      check("after_rst_perr", out_perr, 1'b0);

      // zero-gap frames with a ready consumer
      idle(1, 1);
      send_frame(8'h01, 1'b1, 1'b1, 1);
      check("b2b_0", out_data, 8'h01);
      send_frame(8'h02, 1'b1, 1'b1, 1);
      check("b2b_1", out_data, 8'h02);
      send_frame(8'h03, 1'b0, 1'b1, 1);
      check("b2b_2", out_data, 8'h03);
      check("b2b_valid", out_valid, 1'b1);

      // random traffic, random ready, occasional bad parity/stop and mid-frame reset
      for (int n = 0; n < 300; n++) begin
         idle($urandom_range(0, 3), 2);
         if ($urandom_range(0, 19) == 0) begin
            nb = $urandom_range(0, 9);
            step(1'b0, pick_rdy(2), K_START);
            for (int i = 0; i < nb; i++) step(1'($urandom), pick_rdy(2), K_MID);
            rst_step();
         end else begin
            d    = 8'($urandom);
            par  = (^d) ^ ($urandom_range(0, 4) == 0);
            stop = ($urandom_range(0, 9) != 0);
            send_frame(d, par, stop, 2);
         end
      end
      idle(3, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sipo_frame_rx.md
SIPO_FRAME_RX -- requirements
Module: sipo_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8, number of data bits per frame (>=2).
REQ-002 Parameter PARITY_EN, default 1; 1 = frame carries one even-parity bit, 0 = no parity bit.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port si  input  1  serial line from the upstream shift register output, one bit per clock, idle level 1.
REQ-006 Port out_ready  input  1  consumer accepts out_data when high with out_valid.
REQ-007 Port out_data  output  DATA_W  received data word.
REQ-008 Port out_valid  output  1  out_data holds an unconsumed word.
REQ-009 Port out_perr  output  1  parity error flag for the word on out_data; meaningful only while out_valid=1.
REQ-010 Port frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-011 Port overrun  output  1  one-cycle pulse: completed frame dropped because holding register full.
REQ-012 Port busy  output  1  high whenever FSM is not in IDLE.

Function
REQ-013 Frame format on si SHALL be: start bit 0, DATA_W data bits LSB first, parity bit (if PARITY_EN=1), stop bit 1; one bit per clock, no oversampling.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: si=0 sampled -> DATA with bit counter cleared; si=1 -> stay IDLE.
REQ-016 DATA: each clock shifts si into bit position bit_cnt of the shift register; after DATA_W bits -> PARITY if PARITY_EN=1, else STOP.
REQ-017 PARITY: sample si; parity error = XOR of DATA_W data bits and sampled bit is 1; -> STOP.
REQ-018 STOP: sample si; always -> IDLE next cycle.
REQ-019 Stop bit = 1: frame complete; if PARITY_EN=0 out_perr for the word SHALL be 0.
REQ-020 Stop bit = 0: frame_err SHALL pulse high for exactly the cycle after the stop sample; word discarded; out_valid/out_data/out_perr unchanged.
REQ-021 Latency: out_valid SHALL rise in the cycle immediately following the clock edge that samples a valid stop bit (frame length 2+DATA_W+PARITY_EN cycles).
REQ-022 Handshake: word consumed on any rising edge where out_valid=1 and out_ready=1; out_valid SHALL then fall unless a new word loads on the same edge.
REQ-023 out_data/out_perr SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Completion while out_valid=1 and out_ready=1 on the same edge: new word loads, out_valid stays 1, no overrun.
REQ-025 Completion while out_valid=1 and out_ready=0: new word dropped, held word preserved, overrun pulses one cycle.
REQ-026 A start bit SHALL be accepted in the first cycle after STOP (back-to-back frames, zero idle gap).
REQ-027 Reception SHALL proceed independently of out_ready; receiver never stalls the serial line.
REQ-028 busy SHALL be 1 in DATA, PARITY, STOP and 0 in IDLE.

Reset
REQ-029 With rst=1 at a rising edge: FSM -> IDLE, bit counter and shift register -> 0, out_data=0, out_valid=0, out_perr=0, frame_err=0, overrun=0, busy=0.
REQ-030 Reset asserted mid-frame SHALL abandon the partial frame with no output pulse; the next start bit after rst deasserts starts a fresh frame.
REQ-031 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-032 DATA_W=8, PARITY_EN=1, out_ready=1: si = 1,0,1,0,1,0,0,1,0,1,0,1 (idle, start, 0xA5 LSB first, parity 0, stop) -> out_valid=1 for one cycle, out_data=0xA5, out_perr=0, exactly 1 cycle after stop sample.
REQ-033 Same frame with parity bit 1 -> out_data=0xA5, out_perr=1, frame_err=0.
REQ-034 Frame 0x3C with stop bit 0 -> frame_err pulses one cycle, out_valid stays 0, out_data unchanged.
REQ-035 out_ready=0, frames 0xA5 then 0x5A back-to-back -> out_data=0xA5 held with out_valid=1, overrun pulses once at end of second frame; raising out_ready then drops out_valid next cycle.
REQ-036 rst pulsed after 4 data bits of 0xFF -> busy=0, no outputs change; following frame 0x81 received with out_data=0x81, out_perr=0.
REQ-037 out_ready=1, three frames 0x01,0x02,0x03 with zero idle gap -> three valid words in order, no frame_err or overrun.
